// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if
//   Byte-source / serial-line bundle for uart_transmitter.
//   master: the byte source and line observer (drives tick, wr_en, wr_data).
//   slave : the transmitter (drives tx, busy, tx_done, full, empty, overflow).
//   Signals:
//     tick      baud tick, 1-clk pulse once per bit period
//     wr_en     push wr_data into the write FIFO
//     wr_data   byte to transmit
//     tx        serial line, idle high
//     busy      frame in progress (START..STOP)
//     tx_done   1-clk pulse at the end of each stop bit
//     full      FIFO holds DEPTH entries
//     empty     FIFO holds 0 entries
//     overflow  1-clk pulse when a write is dropped
interface uart_transmitter_if;
  logic       tick;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic       full;
  logic       empty;
  logic       overflow;

  modport master (
    output tick, wr_en, wr_data,
    input  tx, busy, tx_done, full, empty, overflow
  );

  modport slave (
    input  tick, wr_en, wr_data,
    output tx, busy, tx_done, full, empty, overflow
  );
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Serialises bytes from a small write FIFO onto a UART line as 8N1 frames
//   (optionally with a parity bit), LSB first, one bit per baud tick. Queued
//   bytes are sent back-to-back with no idle bit between frames.
//   Ports:
//     clk   system clock, all logic on posedge
//     rst   synchronous active-high reset (control state only)
//     bus   uart_transmitter_if.slave: tick, wr_en, wr_data in;
//           tx, busy, tx_done, full, empty, overflow out (all registered)
module uart_transmitter #(
  parameter int DEPTH      = 4,
  parameter int AW         = 2,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               rst,
  uart_transmitter_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  function automatic logic parity_bit(input logic [7:0] b);
    return (^b) ^ (PARITY_ODD != 0);
  endfunction

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    shift_q;
  logic [2:0]    bit_idx_q;
  logic          par_q;
  logic          tx_q, busy_q, done_q, full_q, empty_q, ovf_q;
  logic          push, pop;

  // Pops happen only when a frame is about to start; the decision uses the
  // registered empty flag so a byte written this cycle waits for a later tick.
  always_comb begin
    push    = bus.wr_en && !full_q;
    pop     = bus.tick && !empty_q && (state_q == S_IDLE || state_q == S_STOP);
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      ovf_q   <= bus.wr_en && full_q;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        shift_q  <= mem_q[rd_ptr_q];
        par_q    <= parity_bit(mem_q[rd_ptr_q]);
      end

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            bit_idx_q <= '0;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (bus.tick) begin
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bus.tick) begin
            if (bit_idx_q != 3'd7) begin
              // Line shows shift_q[0]; the next bit is shift_q[1].
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end else if (PARITY_EN != 0) begin
              tx_q    <= par_q;
              state_q <= S_PARITY;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (bus.tick) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (bus.tick) begin
            done_q <= 1'b1;
            if (pop) begin
              // Next frame starts immediately; busy stays high.
              tx_q      <= 1'b0;
              bit_idx_q <= '0;
              state_q   <= S_START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.tx_done  = done_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
//   Drives three transmitters (no parity, even parity, odd parity) with the
//   same stimulus and checks every output of each against a frame-level model
//   every cycle, plus hand-computed frame expectations.
module tb_uart_transmitter;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  always #5 clk = ~clk;

  uart_transmitter_if if0();
  uart_transmitter_if if1();
  uart_transmitter_if if2();

  assign if0.tick = tick;  assign if0.wr_en = wr_en;  assign if0.wr_data = wr_data;
  assign if1.tick = tick;  assign if1.wr_en = wr_en;  assign if1.wr_data = wr_data;
  assign if2.tick = tick;  assign if2.wr_en = wr_en;  assign if2.wr_data = wr_data;

  uart_transmitter #(.DEPTH(DEPTH), .AW(2), .PARITY_EN(0), .PARITY_ODD(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  uart_transmitter #(.DEPTH(DEPTH), .AW(2), .PARITY_EN(1), .PARITY_ODD(0))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  uart_transmitter #(.DEPTH(DEPTH), .AW(2), .PARITY_EN(1), .PARITY_ODD(1))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [2:0] a_tx, a_busy, a_done, a_full, a_empty, a_ovf;
  assign a_tx    = {if2.tx,       if1.tx,       if0.tx};
  assign a_busy  = {if2.busy,     if1.busy,     if0.busy};
  assign a_done  = {if2.tx_done,  if1.tx_done,  if0.tx_done};
  assign a_full  = {if2.full,     if1.full,     if0.full};
  assign a_empty = {if2.empty,    if1.empty,    if0.empty};
  assign a_ovf   = {if2.overflow, if1.overflow, if0.overflow};

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int done_cnt0 = 0;

  task automatic check(input string name, input int k, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit          pen  [3] = '{1'b0, 1'b1, 1'b1};
  bit          podd [3] = '{1'b0, 1'b0, 1'b1};
  byte unsigned mq  [3][$];
  logic [10:0] fb   [3];
  int          flen [3];
  int          pos  [3];
  logic [2:0]  e_tx = '1, e_busy = '0, e_done = '0, e_full = '0, e_empty = '1, e_ovf = '0;

  task automatic model_step(input int k);
    int   sz;
    bit   do_pop;
    logic [7:0] b;
    if (rst) begin
      mq[k].delete();
      pos[k] = -1;
      e_tx[k] = 1'b1; e_busy[k] = 1'b0; e_done[k] = 1'b0;
      e_full[k] = 1'b0; e_empty[k] = 1'b1; e_ovf[k] = 1'b0;
      return;
    end
    sz = mq[k].size();
    do_pop = 1'b0;
    e_done[k] = 1'b0;
    e_ovf[k] = wr_en && (sz == DEPTH);
    if (tick) begin
      if (pos[k] < 0) begin
        do_pop = (sz > 0);
      end else begin
        pos[k]++;
        if (pos[k] == flen[k]) begin
          e_done[k] = 1'b1;
          if (sz > 0) do_pop = 1'b1;
          else pos[k] = -1;
        end
      end
    end
    if (do_pop) begin
      b = mq[k].pop_front();
      fb[k] = '1;
      fb[k][0] = 1'b0;
      for (int i = 0; i < 8; i++) fb[k][1+i] = b[i];
      if (pen[k]) begin
        fb[k][9] = (^b) ^ podd[k];
        flen[k] = 11;
      end else begin
        flen[k] = 10;
      end
      pos[k] = 0;
    end
    if (wr_en && sz < DEPTH) mq[k].push_back(wr_data);
    e_tx[k]    = (pos[k] < 0) ? 1'b1 : fb[k][pos[k]];
    e_busy[k]  = (pos[k] >= 0);
    e_full[k]  = (mq[k].size() == DEPTH);
    e_empty[k] = (mq[k].size() == 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin pos[k] = -1; flen[k] = 10; fb[k] = '1; end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (a_done[0] === 1'b1) done_cnt0++;
      if (chk_en) begin
        for (int k = 0; k < 3; k++) begin
          check("tx",       k, 16'(a_tx[k]),    16'(e_tx[k]));
          check("busy",     k, 16'(a_busy[k]),  16'(e_busy[k]));
          check("tx_done",  k, 16'(a_done[k]),  16'(e_done[k]));
          check("full",     k, 16'(a_full[k]),  16'(e_full[k]));
          check("empty",    k, 16'(a_empty[k]), 16'(e_empty[k]));
          check("overflow", k, 16'(a_ovf[k]),   16'(e_ovf[k]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic t, input logic we, input logic [7:0] d);
    tick = t; wr_en = we; wr_data = d;
    @(posedge clk); #2;
    tick = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      cyc(1'b1, 1'b0, 8'h00);
      idle(gap - 1);
    end
  endtask

  initial begin
    logic [9:0]  got;
    logic [11:0] p1, p2;
    logic        b0_11, b1_11;
    int          base;
    logic        r_t, r_w;

    rst = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_tx",    0, 16'(if0.tx),       16'd1);
    check("rst_busy",  0, 16'(if0.busy),     16'd0);
    check("rst_empty", 0, 16'(if0.empty),    16'd1);
    check("rst_full",  0, 16'(if0.full),     16'd0);
    check("rst_ovf",   0, 16'(if0.overflow), 16'd0);

    // Single byte 0xA5, tick every 16 clocks.
    base = done_cnt0;
    cyc(1'b0, 1'b1, 8'hA5);
    idle(1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 8'h00);
      got[i] = if0.tx;
      idle(15);
    end
    ticks(3, 16);
    idle(2);
    check("a5_bits", 0, 16'(got), 16'(10'b1101001010));
    check("a5_done", 0, 16'(done_cnt0 - base), 16'd1);
    check("a5_busy", 0, 16'(if0.busy), 16'd0);

    // Three queued bytes go out back-to-back.
    base = done_cnt0;
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'hFF);
    cyc(1'b0, 1'b1, 8'h3C);
    idle(1);
    ticks(36, 16);
    idle(2);
    check("b2b_done",  0, 16'(done_cnt0 - base), 16'd3);
    check("b2b_empty", 0, 16'(if0.empty), 16'd1);

    // Overfill the FIFO with tick held low.
    base = done_cnt0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 8'(8'h10 + i));
      if (i == 2) check("fill_notfull", 0, 16'(if0.full), 16'd0);
      if (i == 3) check("fill_full",    0, 16'(if0.full), 16'd1);
      check("fill_ovf", 0, 16'(if0.overflow), (i >= 4) ? 16'd1 : 16'd0);
    end
    idle(2);
    ticks(50, 3);
    idle(2);
    check("fill_done", 0, 16'(done_cnt0 - base), 16'd4);

    // Parity: 0x07 has three ones.
    cyc(1'b0, 1'b1, 8'h07);
    idle(1);
    b0_11 = 1'b1; b1_11 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, 8'h00);
      p1[i] = if1.tx;
      p2[i] = if2.tx;
      if (i == 10) begin b0_11 = if0.busy; b1_11 = if1.busy; end
      idle(3);
    end
    ticks(2, 4);
    check("par_even_bit", 1, 16'(p1[9]),  16'd1);
    check("par_odd_bit",  2, 16'(p2[9]),  16'd0);
    check("par_stop",     1, 16'(p1[10]), 16'd1);
    check("par_start",    1, 16'(p1[0]),  16'd0);
    check("len10_busy",   0, 16'(b0_11),  16'd0);
    check("len11_busy",   1, 16'(b1_11),  16'd1);

    // Reset during DATA bit 3 of 0x81 with another byte queued.
    base = done_cnt0;
    cyc(1'b0, 1'b1, 8'h81);
    cyc(1'b0, 1'b1, 8'h42);
    idle(1);
    ticks(5, 4);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    check("mid_rst_tx",    0, 16'(if0.tx),      16'd1);
    check("mid_rst_busy",  0, 16'(if0.busy),    16'd0);
    check("mid_rst_empty", 0, 16'(if0.empty),   16'd1);
    check("mid_rst_done",  0, 16'(if0.tx_done), 16'd0);
    idle(3);
    check("mid_rst_nodone", 0, 16'(done_cnt0 - base), 16'd0);
    cyc(1'b0, 1'b1, 8'h55);
    idle(1);
    ticks(13, 5);
    idle(2);
    check("post_rst_done", 0, 16'(done_cnt0 - base), 16'd1);

    // Write in the same cycle as an IDLE tick on an empty FIFO.
    cyc(1'b1, 1'b1, 8'h5A);
    check("same_tick_busy",  0, 16'(if0.busy),  16'd0);
    check("same_tick_tx",    0, 16'(if0.tx),    16'd1);
    check("same_tick_empty", 0, 16'(if0.empty), 16'd0);
    cyc(1'b1, 1'b0, 8'h00);
    check("next_tick_busy", 0, 16'(if0.busy), 16'd1);
    check("next_tick_tx",   0, 16'(if0.tx),   16'd0);
    ticks(14, 4);
    idle(2);

    // Push and pop together at count 2 leave count at 2.
    cyc(1'b0, 1'b1, 8'h11);
    cyc(1'b0, 1'b1, 8'h22);
    cyc(1'b1, 1'b1, 8'h33);
    check("pp_full",  0, 16'(if0.full),  16'd0);
    check("pp_empty", 0, 16'(if0.empty), 16'd0);
    cyc(1'b0, 1'b1, 8'h44);
    check("pp_cnt3_full", 0, 16'(if0.full), 16'd0);
    cyc(1'b0, 1'b1, 8'h55);
    check("pp_cnt4_full", 0, 16'(if0.full), 16'd1);
    check("pp_cnt4_ovf",  0, 16'(if0.overflow), 16'd0);
    cyc(1'b0, 1'b1, 8'h66);
    check("pp_drop_ovf",  0, 16'(if0.overflow), 16'd1);
    ticks(50, 3);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r_t = ($urandom_range(0, 3) == 0);
      r_w = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cyc(r_t, r_w, 8'($urandom));
      rst = 1'b0;
    end
    ticks(60, 2);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
